// File: rtl/register_file_sb_pkg.sv
// Shared types and limits for the scoreboarded register file.
package register_file_sb_pkg;

  localparam int unsigned NUM_READ_MAX = 4;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

endpackage

// File: rtl/register_scoreboard.sv
// Busy bit per register: set marks a pending producer, clear on writeback;
// set wins over clear and register 0 is never busy.
module register_scoreboard
  import register_file_sb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_READ   = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_set,
  input  logic [ADDR_WIDTH-1:0]          i_set_addr,
  input  logic                           i_clr,
  input  logic [ADDR_WIDTH-1:0]          i_clr_addr,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] i_rs,
  output logic [NUM_READ-1:0]            o_busy_c
);

  localparam int unsigned DEPTH = 2**ADDR_WIDTH;

  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_busy_nxt;

  // Clear applied first so a same-cycle set overrides it.
  always_comb begin
    w_busy_nxt = r_busy;
    if (i_clr) w_busy_nxt[i_clr_addr] = 1'b0;
    if (i_set) w_busy_nxt[i_set_addr] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_busy <= '0;
    else        r_busy <= w_busy_nxt;
  end

  for (genvar gi = 0; gi < int'(NUM_READ); gi++) begin : g_port
    assign o_busy_c[gi] = r_busy[i_rs[gi*ADDR_WIDTH +: ADDR_WIDTH]];
  end

endmodule

// File: rtl/register_file_sb.sv
// Register file with post-reset clear sequencer, x0 hardwired to zero and a
// busy scoreboard. Optional write-to-read forwarding: REGISTER_FILE_SB_BYPASS_EN.
module register_file_sb
  import register_file_sb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned NUM_READ   = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] rs,
  output logic [NUM_READ*WIDTH-1:0]      rd_data,
  output logic [NUM_READ-1:0]            rs_busy,
  input  logic [ADDR_WIDTH-1:0]          rd,
  input  logic [WIDTH-1:0]               rd_wd,
  input  logic                           rd_we,
  input  logic                           busy_set,
  input  logic [ADDR_WIDTH-1:0]          busy_rd,
  output logic                           ready
);

  localparam int unsigned DEPTH = 2**ADDR_WIDTH;

  if ((NUM_READ < 1) || (NUM_READ > NUM_READ_MAX)) begin : g_bad_num_read
    $fatal(1, "register_file_sb: NUM_READ must be within 1..4");
  end

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_clr_cnt;
  logic [ADDR_WIDTH-1:0] w_clr_cnt_nxt;
  logic                  r_ready;
  logic                  w_mem_we;
  logic [ADDR_WIDTH-1:0] w_mem_addr;
  logic [WIDTH-1:0]      w_mem_wd;
  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [NUM_READ-1:0]   w_sb_busy_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= CLEAR;
      r_clr_cnt <= '0;
      r_ready   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
      r_ready   <= (w_state_nxt == READY);
    end
  end

  // CLEAR sweeps every entry to zero; the last sweep edge enters READY.
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    w_mem_we      = 1'b0;
    w_mem_addr    = rd;
    w_mem_wd      = rd_wd;
    case (r_state)
      CLEAR: begin
        w_mem_we      = 1'b1;
        w_mem_addr    = r_clr_cnt;
        w_mem_wd      = '0;
        w_clr_cnt_nxt = r_clr_cnt + ADDR_WIDTH'(1);
        if (&r_clr_cnt) w_state_nxt = READY;
      end
      READY: begin
        w_mem_we = rd_we && (rd != '0);
      end
      default: begin
        w_state_nxt = CLEAR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_addr] <= w_mem_wd;
  end

  register_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_READ   (NUM_READ)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_set      (r_ready && busy_set),
    .i_set_addr (busy_rd),
    .i_clr      (r_ready && rd_we),
    .i_clr_addr (rd),
    .i_rs       (rs),
    .o_busy_c   (w_sb_busy_c)
  );

  for (genvar gi = 0; gi < int'(NUM_READ); gi++) begin : g_rd
    logic [ADDR_WIDTH-1:0] w_addr;
    logic                  w_hit;

    assign w_addr = rs[gi*ADDR_WIDTH +: ADDR_WIDTH];
`ifdef REGISTER_FILE_SB_BYPASS_EN
    assign w_hit  = r_ready && rd_we && (rd != '0) && (rd == w_addr);
`else
    assign w_hit  = 1'b0;
`endif

    assign rd_data[gi*WIDTH +: WIDTH] = (!r_ready || (w_addr == '0)) ? '0 :
                                        w_hit ? rd_wd : r_mem[w_addr];
    assign rs_busy[gi] = r_ready && (w_addr != '0) && !w_hit && w_sb_busy_c[gi];
  end

  assign ready = r_ready;

endmodule

// File: doc/register_file_sb.md
REGISTER_FILE_SB -- requirements
Module: register_file_sb

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, register address width; depth is 2**ADDR_WIDTH.
REQ-002 SHALL have parameter WIDTH, default 32, register data width.
REQ-003 SHALL have parameter NUM_READ, default 2, number of read ports; legal range is 1..4.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port rs, input, NUM_READ*ADDR_WIDTH bits: packed read addresses; port i occupies slice i.
REQ-007 SHALL have port rd_data, output, NUM_READ*WIDTH bits: packed read data; port i occupies slice i.
REQ-008 SHALL have port rs_busy, output, NUM_READ bits: pending-writeback flag for each read address.
REQ-009 SHALL have port rd, input, ADDR_WIDTH bits: write address.
REQ-010 SHALL have port rd_wd, input, WIDTH bits: write data.
REQ-011 SHALL have port rd_we, input, 1 bit: write enable; the same write also clears busy for rd.
REQ-012 SHALL have port busy_set, input, 1 bit: marks busy_rd as having a pending producer.
REQ-013 SHALL have port busy_rd, input, ADDR_WIDTH bits: register to mark busy.
REQ-014 SHALL have port ready, output, 1 bit: high once the post-reset clear has completed.

Function
REQ-015 SHALL be a two-state FSM, CLEAR and READY; CLEAR writes 0 to mem[clr_cnt] each cycle, and clr_cnt increments from 0.
REQ-016 SHALL transition CLEAR->READY on the edge that writes mem[2**ADDR_WIDTH-1]; ready rises exactly 2**ADDR_WIDTH cycles after rst_n deasserts.
REQ-017 SHALL, in CLEAR, ignore rd_we and busy_set, drive rd_data all-zero and drive rs_busy all-zero.
REQ-018 SHALL, in READY, read combinationally: rd_data slice i = mem[rs slice i], with zero added latency.
REQ-019 SHALL treat address 0 as hardwired zero: reads return 0, writes are discarded, it is never busy.
REQ-020 SHALL, in READY with rd_we=1 and rd!=0, write rd_wd to mem[rd] on the clock edge and clear busy[rd].
REQ-021 SHALL, on busy_set=1 with busy_rd!=0, set busy[busy_rd]; on set and clear of the same register in one cycle, set wins.
REQ-022 SHALL drive rs_busy bit i = busy[rs slice i], subject to REQ-025.
REQ-023 SHALL allow all read ports to address the same register without interference.

Reset
REQ-024 SHALL, while rst_n=0 (including mid-CLEAR or mid-operation), force state=CLEAR, clr_cnt=0, busy all-zero and ready=0; the clear restarts from 0 after rst_n deasserts.

Configuration
REQ-025 SHALL, with macro REGISTER_FILE_SB_BYPASS_EN defined, forward rd_wd to any read port with rs==rd!=0 while rd_we=1 in READY, and force that port's rs_busy bit to 0.
REQ-026 SHALL, without REGISTER_FILE_SB_BYPASS_EN, return the pre-write mem value and the pre-write busy bit on a same-cycle read.

Structure
REQ-027 SHALL place the state enum (CLEAR, READY) and the NUM_READ_MAX=4 constant in package register_file_sb_pkg.
REQ-028 SHALL implement the busy-bit array, with its set/clear priority and x0 masking, in sub-module register_scoreboard.
REQ-029 SHALL check parameters at elaboration and fail if NUM_READ is outside 1..4.

Verification
REQ-030 SHALL cover: preload garbage, pulse rst_n low, release -> ready=0 for exactly 32 cycles, then 1; all 31 registers read 0.
REQ-031 SHALL cover: write rd=5, wd=0xDEADBEEF; next cycle rs0=rs1=5 -> both ports read 0xDEADBEEF; write rd=0, wd=1 -> x0 still reads 0.
REQ-032 SHALL cover: busy_set on reg 7; rs0=7 -> rs_busy[0]=1; rd_we on rd=7 -> busy cleared next cycle; set+write on 7 in one cycle -> still busy.
REQ-033 SHALL cover: same-cycle rd_we rd=3 wd=0x55 with rs0=3 -> 0x55 and rs_busy=0 with BYPASS_EN; old value and old busy without it.
REQ-034 SHALL cover: rst_n low at clear cycle 10 -> ready=0, busy=0; after release, ready rises 32 cycles later.
REQ-035 SHALL cover: rd_we and busy_set asserted during CLEAR -> no effect; after ready, those registers read 0 and are not busy.
